// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory arbiter slice.
//   req_tag_e  : requester identity (NONE, CPU, VGA, INP)
//   rd_state_e : pending-read tracker states (IDLE, RD_CPU, RD_VGA)
//   GNT_*      : bit positions inside the one-hot grant vector
//   Fret input region defaults and fret word field widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    NONE,
    CPU,
    VGA,
    INP
  } req_tag_e;

  typedef enum logic [1:0] {
    IDLE,
    RD_CPU,
    RD_VGA
  } rd_state_e;

  localparam int unsigned GNT_CPU = 0;
  localparam int unsigned GNT_VGA = 1;
  localparam int unsigned GNT_INP = 2;

  localparam logic [15:0] INPUT_BASE_DEF  = 16'hF000;
  localparam int unsigned INPUT_WORDS_DEF = 20;

  // Fret word layout: {state[3:0], duration[11:0]}
  localparam int unsigned FRET_STATE_W = 4;
  localparam int unsigned FRET_DUR_W   = 12;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the requester handshakes and the RAM pins.
//   CPU : cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_gnt/cpu_rvalid/cpu_rdata out
//   VGA : vga_req/vga_addr in, vga_gnt/vga_rvalid/vga_rdata out
//   INP : in_req/in_idx/in_wdata in, in_gnt out
//   RAM : mem_addr/mem_we/mem_wdata out, mem_rdata in
// modport slave  : the arbiter side
// modport master : the environment side (requesters and RAM macro)
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic              in_req;
  logic [4:0]        in_idx;
  logic [DATA_W-1:0] in_wdata;
  logic              in_gnt;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  vga_req, vga_addr,
    output vga_gnt, vga_rvalid, vga_rdata,
    input  in_req, in_idx, in_wdata,
    output in_gnt,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output vga_req, vga_addr,
    input  vga_gnt, vga_rvalid, vga_rdata,
    output in_req, in_idx, in_wdata,
    input  in_gnt,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter_prio_sel.sv
// arb_prio_sel: combinational three-way priority select.
//   cpu_req, vga_req, in_req : pending requests
//   starve                   : CPU starvation override active
//   gnt[2:0]                 : one-hot grant (bit order GNT_CPU/GNT_VGA/GNT_INP)
// Normal order is VGA > CPU > INP; with starve set the CPU jumps ahead of VGA.
module arb_prio_sel
  import mem_arb_pkg::*;
(
  input  logic       cpu_req,
  input  logic       vga_req,
  input  logic       in_req,
  input  logic       starve,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = '0;
    if (starve && cpu_req) begin
      gnt[GNT_CPU] = 1'b1;
    end else if (vga_req) begin
      gnt[GNT_VGA] = 1'b1;
    end else if (cpu_req) begin
      gnt[GNT_CPU] = 1'b1;
    end else if (in_req) begin
      gnt[GNT_INP] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM (1-cycle read latency)
// between the CPU, the VGA pixel fetcher and the fret-input capture block.
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   bus         : mem_arbiter_if.slave (requester handshakes + RAM pins)
//   starve_flag : CPU starvation override active
//   wp_err      : sticky CPU write-protect violation (MEM_ARB_WRITE_PROTECT_EN only)
// Optional feature macro: MEM_ARB_WRITE_PROTECT_EN -- CPU writes into the fret
// input region are granted but suppressed, and wp_err is raised.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       DATA_W       = 16,
  parameter int unsigned       STARVE_LIMIT = 8,
  parameter logic [ADDR_W-1:0] INPUT_BASE   = ADDR_W'(INPUT_BASE_DEF),
  parameter int unsigned       INPUT_WORDS  = INPUT_WORDS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output logic         starve_flag
`ifdef MEM_ARB_WRITE_PROTECT_EN
  ,
  output logic         wp_err
`endif
);

  localparam int unsigned      CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [2:0]        sel;
  logic [2:0]        gnt;
  req_tag_e          grant_tag;
  logic              mem_we;
  logic [ADDR_W-1:0] in_addr;
  logic              in_drop;
  logic              cpu_wp_hit;

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  rd_state_e         rd_state_q,   rd_state_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
  logic [DATA_W-1:0] vga_rdata_q,  vga_rdata_d;

  assign starve_flag = (starve_cnt_q >= STARVE_MAX);

  arb_prio_sel u_prio_sel (
    .cpu_req (bus.cpu_req),
    .vga_req (bus.vga_req),
    .in_req  (bus.in_req),
    .starve  (starve_flag),
    .gnt     (sel)
  );

  // Grants are combinational, so they are masked while reset is asserted.
  assign gnt = reset ? sel : '0;

  assign bus.cpu_gnt = gnt[GNT_CPU];
  assign bus.vga_gnt = gnt[GNT_VGA];
  assign bus.in_gnt  = gnt[GNT_INP];

  assign in_addr = INPUT_BASE + ADDR_W'(bus.in_idx);
  assign in_drop = (32'(bus.in_idx) >= INPUT_WORDS);

`ifdef MEM_ARB_WRITE_PROTECT_EN
  localparam logic [ADDR_W-1:0] INPUT_END = INPUT_BASE + ADDR_W'(INPUT_WORDS);

  logic wp_err_q, wp_err_d;

  assign cpu_wp_hit = bus.cpu_we && (bus.cpu_addr >= INPUT_BASE) &&
                      (bus.cpu_addr < INPUT_END);
  assign wp_err_d   = wp_err_q | (gnt[GNT_CPU] & cpu_wp_hit);
  assign wp_err     = wp_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wp_err_q <= 1'b0;
    else        wp_err_q <= wp_err_d;
  end
`else
  assign cpu_wp_hit = 1'b0;
`endif

  always_comb begin
    grant_tag = NONE;
    if (gnt[GNT_CPU])      grant_tag = CPU;
    else if (gnt[GNT_VGA]) grant_tag = VGA;
    else if (gnt[GNT_INP]) grant_tag = INP;
  end

  // Issue path plus read-tag next state. The tag is a one-deep pipeline, so
  // the next state depends only on this cycle's grant, never on rd_state_q.
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_we     = 1'b0;
    rd_state_d = IDLE;
    case (grant_tag)
      CPU: begin
        addr_d  = bus.cpu_addr;
        wdata_d = bus.cpu_wdata;
        mem_we  = bus.cpu_we && !cpu_wp_hit;
        if (!bus.cpu_we) rd_state_d = RD_CPU;
      end
      VGA: begin
        addr_d     = bus.vga_addr;
        rd_state_d = RD_VGA;
      end
      INP: begin
        addr_d  = in_addr;
        wdata_d = bus.in_wdata;
        mem_we  = !in_drop;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr  = addr_d;
  assign bus.mem_we    = mem_we;
  assign bus.mem_wdata = wdata_d;

  // Read return: the owner sees RAM data live; the other side holds.
  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    vga_rdata_d = vga_rdata_q;
    if (rd_state_q == RD_CPU) cpu_rdata_d = bus.mem_rdata;
    if (rd_state_q == RD_VGA) vga_rdata_d = bus.mem_rdata;
  end

  assign bus.cpu_rvalid = (rd_state_q == RD_CPU);
  assign bus.vga_rvalid = (rd_state_q == RD_VGA);
  assign bus.cpu_rdata  = cpu_rdata_d;
  assign bus.vga_rdata  = vga_rdata_d;

  always_comb begin
    starve_cnt_d = '0;
    if (bus.cpu_req && !gnt[GNT_CPU]) begin
      starve_cnt_d = (starve_cnt_q >= STARVE_MAX) ? STARVE_MAX
                                                  : starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
      rd_state_q   <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      vga_rdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_state_q   <= rd_state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vga_rdata_q  <= vga_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized bench for mem_arbiter with a RAM
// model and a transaction-level reference model (priority rule, starvation
// count, shadow memory, one-cycle read return).
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int STARVE = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic starve_flag;
`ifdef MEM_ARB_WRITE_PROTECT_EN
  logic wp_err;
`endif

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(
    .ADDR_W       (16),
    .DATA_W       (16),
    .STARVE_LIMIT (STARVE),
    .INPUT_BASE   (16'hF000),
    .INPUT_WORDS  (20)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bus),
    .starve_flag (starve_flag)
`ifdef MEM_ARB_WRITE_PROTECT_EN
    ,
    .wp_err      (wp_err)
`endif
  );

  // RAM macro model: synchronous write, one-cycle registered read.
  logic [15:0] ram [0:65535];
  logic [15:0] ram_rdata;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    ram_rdata <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          m_starve;
  logic [15:0] m_addr;
  int          m_pend;        // 0 none, 1 CPU, 2 VGA
  logic [15:0] m_pend_data;
  logic [15:0] m_cpu_rd, m_vga_rd;
  bit          m_cpu_known, m_vga_known;
  bit          m_wp;
  logic [15:0] shadow [int];

  // Snapshot of DUT outputs from the last cycle() call
  logic        s_cpu_gnt, s_vga_gnt, s_in_gnt, s_mem_we, s_starve, s_wp;
  logic        s_cpu_rvalid, s_vga_rvalid;
  logic [15:0] s_mem_addr, s_cpu_rdata, s_vga_rdata;

  function automatic logic [15:0] init_val(int a);
    if (a == 16'h0010) return 16'h1234;
    return 16'((a * 7) ^ 16'h3C3C);
  endfunction

  function automatic logic [15:0] mem_val(int a);
    if (shadow.exists(a)) return shadow[a];
    return init_val(a);
  endfunction

  function automatic bit in_region(logic [15:0] a);
    return (a >= 16'hF000) && (a < 16'hF014);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0; m_addr = '0; m_pend = 0; m_wp = 1'b0;
    m_cpu_known = 1'b0; m_vga_known = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vga_req = 1'b0; bus.vga_addr = '0;
    bus.in_req  = 1'b0; bus.in_idx = '0; bus.in_wdata = '0;
  endtask

  // One clock: sample at negedge, compare with the model, advance the model,
  // then step past the rising edge.
  task automatic cycle();
    int          who;
    bit          we_exp;
    logic [15:0] a;
    @(negedge clk);
    s_cpu_gnt = bus.cpu_gnt;  s_vga_gnt = bus.vga_gnt; s_in_gnt = bus.in_gnt;
    s_mem_we  = bus.mem_we;   s_mem_addr = bus.mem_addr; s_starve = starve_flag;
    s_cpu_rvalid = bus.cpu_rvalid; s_vga_rvalid = bus.vga_rvalid;
    s_cpu_rdata  = bus.cpu_rdata;  s_vga_rdata  = bus.vga_rdata;
`ifdef MEM_ARB_WRITE_PROTECT_EN
    s_wp = wp_err;
    chk("wp_err", wp_err, m_wp);
`else
    s_wp = 1'b0;
`endif
    who = 0;
    if (bus.cpu_req && m_starve >= STARVE) who = 1;
    else if (bus.vga_req)                  who = 2;
    else if (bus.cpu_req)                  who = 1;
    else if (bus.in_req)                   who = 3;

    chk("starve_flag", starve_flag, m_starve >= STARVE);
    chk("cpu_gnt", bus.cpu_gnt, who == 1);
    chk("vga_gnt", bus.vga_gnt, who == 2);
    chk("in_gnt",  bus.in_gnt,  who == 3);

    chk("cpu_rvalid", bus.cpu_rvalid, m_pend == 1);
    chk("vga_rvalid", bus.vga_rvalid, m_pend == 2);
    if (m_pend == 1) begin m_cpu_rd = m_pend_data; m_cpu_known = 1'b1; end
    if (m_pend == 2) begin m_vga_rd = m_pend_data; m_vga_known = 1'b1; end
    if (m_cpu_known) chk("cpu_rdata", bus.cpu_rdata, m_cpu_rd);
    if (m_vga_known) chk("vga_rdata", bus.vga_rdata, m_vga_rd);

    we_exp = 1'b0;
    m_pend = 0;
    case (who)
      1: begin
        m_addr = bus.cpu_addr;
        if (bus.cpu_we) begin
`ifdef MEM_ARB_WRITE_PROTECT_EN
          if (in_region(bus.cpu_addr)) m_wp = 1'b1;
          else we_exp = 1'b1;
`else
          we_exp = 1'b1;
`endif
          if (we_exp) chk("cpu_wdata", bus.mem_wdata, bus.cpu_wdata);
        end else begin
          m_pend = 1; m_pend_data = mem_val(int'(bus.cpu_addr));
        end
      end
      2: begin
        m_addr = bus.vga_addr;
        m_pend = 2; m_pend_data = mem_val(int'(bus.vga_addr));
      end
      3: begin
        m_addr = 16'hF000 + 16'(bus.in_idx);
        we_exp = (bus.in_idx < 5'd20);
        if (we_exp) chk("in_wdata", bus.mem_wdata, bus.in_wdata);
      end
      default: ;
    endcase
    chk("mem_we", bus.mem_we, we_exp);
    chk("mem_addr", bus.mem_addr, m_addr);
    if (we_exp) begin
      a = m_addr;
      shadow[int'(a)] = bus.mem_wdata;
    end
    if (bus.cpu_req && who != 1) m_starve = (m_starve + 1 > STARVE) ? STARVE : m_starve + 1;
    else m_starve = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = init_val(i);
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_gnt", bus.cpu_gnt, 1'b0);
    chk("rst_vga_gnt", bus.vga_gnt, 1'b0);
    chk("rst_in_gnt",  bus.in_gnt, 1'b0);
    chk("rst_mem_we",  bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_mem_wdata", bus.mem_wdata, 16'h0000);
    chk("rst_starve", starve_flag, 1'b0);
    chk("rst_rvalid", {bus.cpu_rvalid, bus.vga_rvalid}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // CPU read of 0x0010
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
    cycle();
    chk("t1_gnt", s_cpu_gnt, 1'b1);
    bus.cpu_req = 1'b0;
    cycle();
    chk("t1_rvalid", s_cpu_rvalid, 1'b1);
    chk("t1_rdata", s_cpu_rdata, 16'h1234);

    // VGA vs CPU contention: 8 VGA grants, then the starved CPU wins
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0020;
    bus.vga_req = 1'b1; bus.vga_addr = 16'h0030;
    for (int i = 0; i < STARVE; i++) begin
      cycle();
      chk("t2_vga_gnt", s_vga_gnt, 1'b1);
      chk("t2_cpu_wait", s_cpu_gnt, 1'b0);
    end
    cycle();
    chk("t2_starve_flag", s_starve, 1'b1);
    chk("t2_cpu_gnt", s_cpu_gnt, 1'b1);
    bus.cpu_req = 1'b0;
    cycle();
    chk("t2_starve_clr", s_starve, 1'b0);
    bus.vga_req = 1'b0;
    cycle();

    // Fret writes: valid index and out-of-range index
    bus.in_req = 1'b1; bus.in_idx = 5'd3;
    bus.in_wdata = {4'h4, 12'd500};
    cycle();
    chk("t3_in_gnt", s_in_gnt, 1'b1);
    chk("t3_addr", s_mem_addr, 16'hF003);
    chk("t3_we", s_mem_we, 1'b1);
    bus.in_idx = 5'd20; bus.in_wdata = 16'hDEAD;
    cycle();
    chk("t3_drop_gnt", s_in_gnt, 1'b1);
    chk("t3_drop_we", s_mem_we, 1'b0);
    bus.in_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'hF003;
    cycle();
    bus.cpu_req = 1'b0;
    cycle();
    chk("t3_readback", s_cpu_rdata, 16'h41F4);

    // Back-to-back VGA then CPU reads
    bus.vga_req = 1'b1; bus.vga_addr = 16'h0040;
    cycle();
    bus.vga_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0050;
    cycle();
    chk("t4_vga_rvalid", s_vga_rvalid, 1'b1);
    chk("t4_vga_rdata", s_vga_rdata, init_val(16'h0040));
    chk("t4_cpu_no_rvalid", s_cpu_rvalid, 1'b0);
    bus.cpu_req = 1'b0;
    cycle();
    chk("t4_cpu_rvalid", s_cpu_rvalid, 1'b1);
    chk("t4_cpu_rdata", s_cpu_rdata, init_val(16'h0050));
    chk("t4_vga_hold", s_vga_rdata, init_val(16'h0040));

    // Reset the cycle after a CPU read grant
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0060;
    cycle();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_rvalid", bus.cpu_rvalid, 1'b0);
    chk("t5_rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("t5_rst_mem_we", bus.mem_we, 1'b0);
    chk("t5_rst_starve", starve_flag, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();
    chk("t5_no_rvalid", s_cpu_rvalid, 1'b0);
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0070;
    cycle();
    chk("t5_resume", s_cpu_gnt, 1'b1);
    bus.cpu_req = 1'b0;
    cycle();

    // CPU write into the fret region
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'hF005; bus.cpu_wdata = 16'hBEEF;
    cycle();
    chk("t6_gnt", s_cpu_gnt, 1'b1);
`ifdef MEM_ARB_WRITE_PROTECT_EN
    chk("t6_we_blocked", s_mem_we, 1'b0);
`else
    chk("t6_we", s_mem_we, 1'b1);
`endif
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    cycle();
`ifdef MEM_ARB_WRITE_PROTECT_EN
    chk("t6_wp_err", s_wp, 1'b1);
`endif
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'hF005;
    cycle();
    bus.cpu_req = 1'b0;
    cycle();
`ifdef MEM_ARB_WRITE_PROTECT_EN
    chk("t6_ram_unchanged", s_cpu_rdata, init_val(16'hF005));
    chk("t6_wp_sticky", s_wp, 1'b1);
`else
    chk("t6_ram_written", s_cpu_rdata, 16'hBEEF);
`endif

    // Randomized traffic; requesters hold until granted
    for (int n = 0; n < 800; n++) begin
      if (!bus.cpu_req && $urandom_range(0, 99) < 50) begin
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = $urandom_range(0, 1) == 1;
        bus.cpu_addr  = ($urandom_range(0, 3) == 0) ? 16'hF000 + 16'($urandom_range(0, 23))
                                                    : 16'($urandom_range(0, 63));
        bus.cpu_wdata = 16'($urandom);
      end
      if (!bus.vga_req && $urandom_range(0, 99) < 75) begin
        bus.vga_req  = 1'b1;
        bus.vga_addr = ($urandom_range(0, 3) == 0) ? 16'hF000 + 16'($urandom_range(0, 19))
                                                   : 16'($urandom_range(0, 63));
      end
      if (!bus.in_req && $urandom_range(0, 99) < 40) begin
        bus.in_req   = 1'b1;
        bus.in_idx   = 5'($urandom_range(0, 23));
        bus.in_wdata = 16'($urandom);
      end
      cycle();
      if (s_cpu_gnt) bus.cpu_req = 1'b0;
      if (s_vga_gnt) bus.vga_req = 1'b0;
      if (s_in_gnt)  bus.in_req  = 1'b0;
    end
    idle_inputs();
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous 16-bit RAM (one-cycle read latency) between three requesters: CPU load/store/fetch, VGA pixel fetch, and fret-input capture.
- The fret-input requester writes fret words into the input region at 16'hF000–16'hF013.
- Sits between the CPU, VGA controller, input block and the RAM macro; owns the RAM address, write-enable and write-data pins.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- STARVE_LIMIT, 8, consecutive CPU wait cycles after which the CPU beats VGA for the next grant.
- INPUT_BASE, 16'hF000, base of the fret input region.
- INPUT_WORDS, 20, number of fret words in the input region.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  16  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU access issued this cycle.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata is valid.
- cpu_rdata  out  16  read data for the CPU.
- vga_req  in  1  VGA read request; held until vga_gnt.
- vga_addr  in  16  VGA read address.
- vga_gnt  out  1  one-cycle pulse: VGA read issued.
- vga_rvalid  out  1  one-cycle pulse: vga_rdata is valid.
- vga_rdata  out  16  read data for VGA.
- in_req  in  1  fret capture write request.
- in_idx  in  5  fret index, 0–19.
- in_wdata  in  16  fret word {4-bit state, 12-bit duration}.
- in_gnt  out  1  one-cycle pulse: fret write issued.
- mem_addr  out  16  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  16  RAM write data.
- mem_rdata  in  16  RAM read data, valid one cycle after the address.
- starve_flag  out  1  high while the CPU starvation override is active.

Behaviour:
- Reset (reset=0, asynchronous): all gnt, rvalid, mem_we and starve_flag = 0; mem_addr = 0; mem_wdata = 0; starve counter = 0; pending-read tag = NONE.
- Issue, per cycle, at most one access. Priority:
  - VGA first, unless starve_cnt ≥ STARVE_LIMIT, in which case CPU first.
  - Then CPU, then fret input.
- mem_addr, mem_we and mem_wdata are driven combinationally from the granted requester in the grant cycle.
- When nothing is granted: mem_we = 0 and mem_addr holds its last value.
- Fret write address = INPUT_BASE + in_idx.
  - If in_idx ≥ INPUT_WORDS, grant and consume the request but force mem_we = 0 (dropped).
- Read return:
  - Latch the requester tag on a read grant.
  - Next cycle, pulse the owner's rvalid and route mem_rdata to that owner's rdata.
  - The non-owner's rdata holds its last value.
- Back-to-back reads from different requesters are allowed; the tag is a one-deep pipeline.
- CPU write: cpu_gnt pulses, no cpu_rvalid follows.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle that cpu_req=1 and cpu_gnt=0.
  - Clears on cpu_gnt or when cpu_req=0.
  - starve_flag = (starve_cnt ≥ STARVE_LIMIT).
- Simultaneous requests: exactly one gnt is high; losers keep their requests asserted and the arbiter re-evaluates next cycle.
- Reset mid-read: the pending tag is cleared and no rvalid is produced after reset deasserts.
- FSM on tag: IDLE → RD_CPU / RD_VGA on a read grant.
  - From RD_*: go to the new tag if a read is granted this cycle, else IDLE.

Optional Feature:
- Macro: MEM_ARB_WRITE_PROTECT_EN.
- When defined:
  - A CPU write whose address falls in [INPUT_BASE, INPUT_BASE+INPUT_WORDS) is granted but mem_we is forced to 0.
  - A sticky output wp_err (1 bit, cleared only by reset) is set.
- When undefined: no wp_err port; CPU writes to the input region proceed normally.

Decomposition:
- Package mem_arb_pkg holds:
  - Requester tag enum: NONE, CPU, VGA, INP.
  - INPUT_BASE and INPUT_WORDS defaults.
  - Fret word field widths (4 state, 12 duration).
- One sub-module, arb_prio_sel: combinational three-way priority select with starvation override, outputting a one-hot grant.

Test Plan:
- CPU read only: cpu_req, addr 16'h0010, RAM[0x10]=16'h1234 → cpu_gnt in cycle N, cpu_rvalid and cpu_rdata=16'h1234 in N+1.
- VGA and CPU request together each cycle, STARVE_LIMIT=8 → vga_gnt for 8 cycles, then starve_flag=1 and cpu_gnt on cycle 9, after which the counter clears.
- Fret write in_idx=3, in_wdata={4'h4,12'd500} → mem_addr=16'hF003, mem_we=1 and in_gnt pulse when CPU/VGA idle; in_idx=20 → in_gnt pulses with mem_we=0.
- VGA read at N, CPU read at N+1 (different addrs) → vga_rvalid at N+1 with VGA data, cpu_rvalid at N+2 with CPU data; no cross-routing.
- Reset asserted the cycle after a CPU read grant → cpu_rvalid stays 0; all outputs at reset values; normal grants resume after release.
- With MEM_ARB_WRITE_PROTECT_EN: CPU write to 16'hF005 → cpu_gnt=1, mem_we=0, wp_err=1 and sticky; RAM[0xF005] is unchanged.
